// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/DE hazard and sequencing controller
// Load-use stall, taken-branch flush and memory-busy freeze with saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int KILL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifde_en,
  output logic             branch_kill_flag,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  localparam logic [1:0]       KILL_INIT = 2'(KILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [1:0]       kill_ctr_q, kill_ctr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic hazard;
  logic br;
  logic pc_c, ifde_c, kill_c, bubble_c;
  logic stall_inc, flush_inc;

  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((ex_rd == de_rs1) || (de_uses_rs2 && (ex_rd == de_rs2)));
  assign br     = branch_taken | pending_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    kill_ctr_d = kill_ctr_q;
    pc_c       = 1'b1;
    ifde_c     = 1'b1;
    kill_c     = 1'b0;
    bubble_c   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    case (state_q)
      FLUSH: begin
        // EX holds a bubble here, so a branch_taken seen now is spurious.
        if (mem_busy) begin
          pc_c   = 1'b0;
          ifde_c = 1'b0;
        end else begin
          kill_c     = 1'b1;
          bubble_c   = 1'b1;
          kill_ctr_d = kill_ctr_q - 2'd1;
          if (kill_ctr_q <= 2'd1) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        // RUN, LU_STALL and MEM_WAIT share priority mem_busy > br > hazard;
        // pending_q can only be set on entry to MEM_WAIT.
        if (mem_busy) begin
          pc_c      = 1'b0;
          ifde_c    = 1'b0;
          pending_d = pending_q | branch_taken;
          state_d   = MEM_WAIT;
        end else if (br) begin
          kill_c     = 1'b1;
          bubble_c   = 1'b1;
          flush_inc  = 1'b1;
          kill_ctr_d = KILL_INIT;
          pending_d  = 1'b0;
          state_d    = (KILL_CYCLES > 1) ? FLUSH : RUN;
        end else if (hazard && (state_q != LU_STALL)) begin
          pc_c      = 1'b0;
          ifde_c    = 1'b0;
          bubble_c  = 1'b1;
          stall_inc = 1'b1;
          state_d   = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
    endcase

    stall_d = (stall_inc && (stall_q != CNT_MAX)) ? stall_q + CNT_ONE : stall_q;
    flush_d = (flush_inc && (flush_q != CNT_MAX)) ? flush_q + CNT_ONE : flush_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pending_q  <= 1'b0;
      kill_ctr_q <= 2'd0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      kill_ctr_q <= kill_ctr_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  // Outputs are forced to a safe hold-and-bubble pattern while reset is low.
  assign pc_en            = rst_n & pc_c;
  assign ifde_en          = rst_n & ifde_c;
  assign branch_kill_flag = rst_n & kill_c;
  assign idex_bubble      = ~rst_n | bubble_c;
  assign state            = state_q;
  assign stall_cnt        = stall_q;
  assign flush_cnt        = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] de_rs1, de_rs2, ex_rd;
  logic       de_uses_rs2, ex_mem_read, branch_taken, mem_busy;
  logic       pc_en, ifde_en, branch_kill_flag, idex_bubble;
  logic [1:0] state;
  logic [1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  logic [9:0] exp_q[$];
  string      name_q[$];

  pipeline_hazard_ctrl #(.KILL_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_uses_rs2(de_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifde_en(ifde_en), .branch_kill_flag(branch_kill_flag),
    .idex_bubble(idex_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the expected Mealy outputs for it.
  task automatic cyc(input string nm, input logic rn, input logic busy, input logic bt,
                     input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u2,
                     input logic pc, input logic ie, input logic k, input logic b,
                     input logic [1:0] st, input logic [1:0] sc, input logic [1:0] fc);
    @(posedge clk);
    #1;
    rst_n        = rn;
    mem_busy     = busy;
    branch_taken = bt;
    ex_mem_read  = mr;
    ex_rd        = rd;
    de_rs1       = rs1;
    de_rs2       = rs2;
    de_uses_rs2  = u2;
    exp_q.push_back({pc, ie, k, b, st, sc, fc});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e, a;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_en, ifde_en, branch_kill_flag, idex_bubble, state, stall_cnt, flush_cnt};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got pc/ie/kill/bub/st/sc/fc=%b expected %b", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
    ex_rd = 5'd3; de_rs1 = 5'd1; de_rs2 = 5'd2; de_uses_rs2 = 1'b1;

    //   name          rn bz bt mr rd     rs1    rs2    u2    pc ie k  b  st    sc    fc
    cyc("reset",       0, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 1, 2'd0, 2'd0, 2'd0);
    cyc("idle0",       1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    cyc("lu_rs1",      1, 0, 0, 1, 5'd5,  5'd5,  5'd2,  1,    0, 0, 0, 1, 2'd0, 2'd0, 2'd0);
    cyc("lu_stall",    1, 0, 0, 1, 5'd5,  5'd5,  5'd2,  1,    1, 1, 0, 0, 2'd1, 2'd1, 2'd0);
    cyc("x0_nostall",  1, 0, 0, 1, 5'd0,  5'd0,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd1, 2'd0);
    cyc("rs2_unused",  1, 0, 0, 1, 5'd7,  5'd1,  5'd7,  0,    1, 1, 0, 0, 2'd0, 2'd1, 2'd0);
    cyc("lu_rs2",      1, 0, 0, 1, 5'd7,  5'd1,  5'd7,  1,    0, 0, 0, 1, 2'd0, 2'd1, 2'd0);
    cyc("lu_stall2",   1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd1, 2'd2, 2'd0);
    cyc("br_kill1",    1, 0, 1, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd0, 2'd2, 2'd0);
    cyc("br_kill2",    1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd2, 2'd2, 2'd1);
    cyc("br_done",     1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd2, 2'd1);
    cyc("busy_br1",    1, 1, 1, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 0, 2'd0, 2'd2, 2'd1);
    cyc("busy_br2",    1, 1, 0, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 0, 2'd3, 2'd2, 2'd1);
    cyc("busy_br3",    1, 1, 0, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 0, 2'd3, 2'd2, 2'd1);
    cyc("pend_kill1",  1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd3, 2'd2, 2'd1);
    cyc("pend_kill2",  1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd2, 2'd2, 2'd2);
    cyc("pend_done",   1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd2, 2'd2);
    cyc("fl_kill1",    1, 0, 1, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd0, 2'd2, 2'd2);
    cyc("fl_busy1",    1, 1, 0, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 0, 2'd2, 2'd2, 2'd3);
    cyc("fl_busy2_bt", 1, 1, 1, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 0, 2'd2, 2'd2, 2'd3);
    cyc("fl_kill2",    1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd2, 2'd2, 2'd3);
    cyc("fl_done",     1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd2, 2'd3);
    cyc("br_over_haz", 1, 0, 1, 1, 5'd5,  5'd5,  5'd2,  1,    1, 1, 1, 1, 2'd0, 2'd2, 2'd3);
    cyc("flush_haz",   1, 0, 0, 1, 5'd5,  5'd5,  5'd2,  1,    1, 1, 1, 1, 2'd2, 2'd2, 2'd3);
    cyc("fcnt_sat",    1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd2, 2'd3);
    cyc("haz3",        1, 0, 0, 1, 5'd5,  5'd5,  5'd2,  1,    0, 0, 0, 1, 2'd0, 2'd2, 2'd3);
    cyc("haz3_stall",  1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd1, 2'd3, 2'd3);
    cyc("haz4",        1, 0, 0, 1, 5'd5,  5'd5,  5'd2,  1,    0, 0, 0, 1, 2'd0, 2'd3, 2'd3);
    cyc("scnt_sat",    1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd1, 2'd3, 2'd3);
    cyc("busy_haz",    1, 1, 0, 1, 5'd5,  5'd5,  5'd2,  1,    0, 0, 0, 0, 2'd0, 2'd3, 2'd3);
    cyc("mw_haz",      1, 0, 0, 1, 5'd5,  5'd5,  5'd2,  1,    0, 0, 0, 1, 2'd3, 2'd3, 2'd3);
    cyc("mw_haz_stl",  1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd1, 2'd3, 2'd3);
    cyc("rstfl_br",    1, 0, 1, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 1, 1, 2'd0, 2'd3, 2'd3);
    cyc("rst_in_fl",   0, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 1, 2'd0, 2'd0, 2'd0);
    cyc("after_rstfl", 1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    cyc("rstmw_br",    1, 1, 1, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    cyc("rst_in_mw",   0, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    0, 0, 0, 1, 2'd0, 2'd0, 2'd0);
    cyc("pend_drop1",  1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    cyc("pend_drop2",  1, 0, 0, 0, 5'd3,  5'd1,  5'd2,  1,    1, 1, 0, 0, 2'd0, 2'd0, 2'd0);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
